// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one hex nibble per digit slot, anti-ghost blanking,
// optional leading-zero suppression, value snapshot per frame. All outputs registered from next state.
module seg7_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 16,
    localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*DIGITS-1:0]     value,
    input  logic                    freeze,
    input  logic [PRESCALE_W-1:0]   period,
    input  logic [PRESCALE_W-1:0]   blank,
    input  logic                    lz_suppress,
    input  logic                    seg_pol,
    input  logic                    dig_pol,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       dig_en,
    output logic [IW-1:0]           cur_digit,
    output logic                    frame_tick
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PRESCALE_W-1:0]   cnt_q, cnt_d;
    logic [PRESCALE_W-1:0]   p_q, p_d;
    logic [PRESCALE_W-1:0]   b_q, b_d;
    logic [4*DIGITS-1:0]     snap_q, snap_d;
    logic [6:0]              seg_q, seg_d;
    logic [DIGITS-1:0]       dig_en_q, dig_en_d;
    logic                    tick_q, tick_d;

    logic [PRESCALE_W-1:0]   p_in, b_in;
    logic [6:0]              seg_off, seg_on;
    logic [DIGITS-1:0]       dig_off;
    logic                    suppress;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;  default: decode = 7'h71;
        endcase
    endfunction

    // Effective slot timing, latched only when a new slot begins
    assign p_in    = (period == '0) ? PRESCALE_W'(1) : period;
    assign b_in    = (blank > p_in - PRESCALE_W'(1)) ? p_in - PRESCALE_W'(1) : blank;
    assign seg_off = seg_pol ? 7'h00 : 7'h7F;
    assign dig_off = dig_pol ? '0 : '1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        snap_d  = snap_q;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    snap_d  = value;
                    idx_d   = '0;
                    cnt_d   = '0;
                    p_d     = p_in;
                    b_d     = b_in;
                    state_d = (b_in != '0) ? BLANK : SHOW;
                end
                BLANK: begin
                    cnt_d = cnt_q + PRESCALE_W'(1);
                    if (cnt_q == b_q - PRESCALE_W'(1)) state_d = SHOW;
                end
                default: begin
                    if (cnt_q == p_q - PRESCALE_W'(1)) begin
                        cnt_d   = '0;
                        p_d     = p_in;
                        b_d     = b_in;
                        state_d = (b_in != '0) ? BLANK : SHOW;
                        if (idx_q == IW'(DIGITS - 1)) begin
                            idx_d = '0;
                            if (!freeze) snap_d = value;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + PRESCALE_W'(1);
                    end
                end
            endcase
        end
    end

    // A digit is a leading zero when it and every more-significant nibble are zero
    assign suppress = lz_suppress && (idx_d != '0) && ((snap_d >> {idx_d, 2'b00}) == '0);
    assign seg_on   = suppress ? seg_off : (decode(snap_d[4*idx_d +: 4]) ^ seg_off);

    always_comb begin
        seg_d    = seg_off;
        dig_en_d = dig_off;
        tick_d   = 1'b0;
        if (state_d == SHOW) begin
            seg_d    = seg_on;
            dig_en_d = (DIGITS'(1) << idx_d) ^ dig_off;
            tick_d   = (idx_d == IW'(DIGITS - 1)) && (cnt_d == p_d - PRESCALE_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            p_q      <= PRESCALE_W'(1);
            b_q      <= '0;
            snap_q   <= '0;
            seg_q    <= seg_off;
            dig_en_q <= dig_off;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            b_q      <= b_d;
            snap_q   <= snap_d;
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
            tick_q   <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign cur_digit  = idx_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed + randomized bench for seg7_scan_ctrl against a slot-timeline reference model.
module tb_seg7_scan_ctrl;

    localparam int D  = 4;
    localparam int PW = 16;
    localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic            clk = 1'b0;
    logic            reset, enable, freeze, lz_suppress, seg_pol, dig_pol;
    logic [4*D-1:0]  value;
    logic [PW-1:0]   period, blank;
    logic [6:0]      seg;
    logic [D-1:0]    dig_en;
    logic [1:0]      cur_digit;
    logic            frame_tick;

    int tests = 0;
    int fails = 0;

    // Reference model: position on the slot timeline
    bit             m_active;
    int             m_k, m_el, m_p, m_b;
    logic [15:0]    m_snap;
    logic [6:0]     e_seg;
    logic [D-1:0]   e_dig;
    int             e_cur;
    bit             e_tick;

    seg7_scan_ctrl #(.DIGITS(D), .PRESCALE_W(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .value(value), .freeze(freeze),
        .period(period), .blank(blank), .lz_suppress(lz_suppress), .seg_pol(seg_pol),
        .dig_pol(dig_pol), .seg(seg), .dig_en(dig_en), .cur_digit(cur_digit),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample_timing();
        m_p = (period == 0) ? 1 : int'(period);
        m_b = (int'(blank) > m_p - 1) ? m_p - 1 : int'(blank);
    endtask

    task automatic model_step();
        bit showing, zero;
        if (reset) begin
            m_active = 0; m_k = 0; m_el = 0; m_snap = '0; m_p = 1; m_b = 0;
        end else if (!enable) begin
            m_active = 0; m_k = 0; m_el = 0;
        end else if (!m_active) begin
            m_active = 1; m_snap = value; m_k = 0; m_el = 0;
            sample_timing();
        end else begin
            m_el++;
            if (m_el == m_p) begin
                m_el = 0;
                if (m_k == D - 1) begin
                    m_k = 0;
                    if (!freeze) m_snap = value;
                end else begin
                    m_k++;
                end
                sample_timing();
            end
        end
        showing = m_active && (m_el >= m_b);
        zero = 1;
        for (int j = m_k; j < D; j++) if (m_snap[4*j +: 4] != 0) zero = 0;
        e_seg  = '0;
        e_dig  = '0;
        if (showing) begin
            e_dig = D'(1) << m_k;
            if (!(lz_suppress && m_k > 0 && zero)) e_seg = DEC[m_snap[4*m_k +: 4]];
        end
        if (!seg_pol) e_seg = ~e_seg;
        if (!dig_pol) e_dig = ~e_dig;
        e_cur  = m_active ? m_k : 0;
        e_tick = showing && (m_k == D - 1) && (m_el == m_p - 1);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check("seg", 32'(seg), 32'(e_seg));
            check("dig_en", 32'(dig_en), 32'(e_dig));
            check("cur_digit", 32'(cur_digit), 32'(e_cur));
            check("frame_tick", 32'(frame_tick), 32'(e_tick));
        end
    endtask

    task automatic setup(input logic [15:0] v, input int per, input int blk);
        value = v; period = PW'(per); blank = PW'(blk);
    endtask

    initial begin
        int ticks;
        reset = 1; enable = 0; freeze = 0; lz_suppress = 0; seg_pol = 1; dig_pol = 1;
        setup(16'h1234, 4, 1);
        cyc(2);
        check("reset_seg", 32'(seg), 32'h00);
        check("reset_dig", 32'(dig_en), 32'h0);
        reset = 0;
        cyc(2);

        // Scan order and frame rate
        enable = 1;
        ticks = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            if (frame_tick) ticks++;
            if (i == 1) check("t1_first_show", 32'({dig_en, seg}), 32'({4'b0001, 7'h66}));
        end
        check("t1_ticks", 32'(ticks), 32'd4);

        // Value change mid-frame, then freeze
        cyc(5);
        value = 16'hABCD;
        cyc(40);
        freeze = 1;
        value = 16'h1234;
        cyc(40);
        freeze = 0;

        // Leading-zero suppression
        lz_suppress = 1;
        value = 16'h0005;
        cyc(40);
        value = 16'h0000;
        cyc(40);
        lz_suppress = 0;

        // Polarity inversion
        seg_pol = 0; dig_pol = 0; value = 16'h0008;
        cyc(36);
        seg_pol = 1; dig_pol = 1;

        // Boundary timing
        setup(16'hF0E1, 0, 5);
        cyc(20);
        setup(16'h7A3C, 3, 9);
        cyc(30);

        // Abort mid-SHOW and mid-frame reset
        setup(16'h1234, 4, 1);
        cyc(7);
        enable = 0;
        cyc(1);
        check("abort_dig", 32'(dig_en), 32'h0);
        cyc(3);
        enable = 1;
        cyc(9);
        reset = 1;
        cyc(1);
        reset = 0;
        enable = 0;
        cyc(2);
        enable = 1;
        cyc(20);

        // Randomized segments
        for (int s = 0; s < 60; s++) begin
            setup(16'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
            freeze      = ($urandom_range(0, 3) == 0);
            lz_suppress = $urandom_range(0, 1);
            seg_pol     = $urandom_range(0, 1);
            dig_pol     = $urandom_range(0, 1);
            enable      = ($urandom_range(0, 5) != 0);
            reset       = ($urandom_range(0, 9) == 0);
            cyc(1);
            reset = 0;
            if ($urandom_range(0, 1) == 1)
                value = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
            cyc(int'($urandom_range(5, 60)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
